// File: rtl/robot_uart_pkg.sv
// robot_uart_pkg
// Shared constants and state encodings for the robot UART return-stream receiver.
//   HDR_BYTE   : sensor-stream frame header (0x13)
//   SENSOR_ID  : packet ID of the bump/wheel-drop sensor byte (7)
//   rx_state_t : byte receiver states
//   parse_state_t : frame parser states
//   baud_div() : rounded clock divider for the oversampling tick
package robot_uart_pkg;

  localparam int         DATA_W    = 8;
  localparam logic [7:0] HDR_BYTE  = 8'h13;
  localparam logic [7:0] SENSOR_ID = 8'h07;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } rx_state_t;

  typedef enum logic [1:0] {
    WAIT_HDR,
    GET_LEN,
    GET_PAY,
    GET_CSUM
  } parse_state_t;

  // round(clk_freq / (baud * os)) using integer arithmetic
  function automatic int baud_div(input int clk_freq, input int baud, input int os);
    return (clk_freq + (baud * os) / 2) / (baud * os);
  endfunction

endpackage

// File: rtl/robot_uart_stream_rx_core.sv
// uart_rx_core
// 8N1 byte receiver: two-flop synchroniser, oversampling tick divider and
// receiver FSM.
//   clk, rst_n   : system clock, asynchronous active-low reset
//   rx_async     : raw serial line (idles high)
//   byte_data    : last good byte
//   byte_valid   : one-cycle strobe, cycle after the mid-stop-bit sample
//   framing_err  : one-cycle strobe when the stop bit is sampled low
module uart_rx_core
  import robot_uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115_200,
  parameter int OVERSAMPLE = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                rx_async,
  output logic [DATA_W-1:0]   byte_data,
  output logic                byte_valid,
  output logic                framing_err
);

  localparam int DIV   = baud_div(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int OS_W  = $clog2(OVERSAMPLE);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [OS_W-1:0]  SMP_MID  = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [OS_W-1:0]  SMP_LAST = OS_W'(OVERSAMPLE - 1);

  logic              sync_p0, sync_p1, line_p2;
  logic              line, fall, tick;

  rx_state_t         state, state_n;
  logic [DIV_W-1:0]  div_cnt, div_n;
  logic [OS_W-1:0]   smp_cnt, smp_n;
  logic [2:0]        bit_idx, bit_n;
  logic [DATA_W-1:0] shift, shift_n;
  logic [DATA_W-1:0] data_n;
  logic              bv_n, fe_n;

  // stage p0/p1: metastability synchroniser; p2: edge-detect history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
      line_p2 <= 1'b1;
    end else begin
      sync_p0 <= rx_async;
      sync_p1 <= sync_p0;
      line_p2 <= sync_p1;
    end
  end

  assign line = sync_p1;
  assign fall = line_p2 & ~line;
  assign tick = (div_cnt == DIV_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      div_cnt     <= '0;
      smp_cnt     <= '0;
      bit_idx     <= '0;
      shift       <= '0;
      byte_data   <= '0;
      byte_valid  <= 1'b0;
      framing_err <= 1'b0;
    end else begin
      state       <= state_n;
      div_cnt     <= div_n;
      smp_cnt     <= smp_n;
      bit_idx     <= bit_n;
      shift       <= shift_n;
      byte_data   <= data_n;
      byte_valid  <= bv_n;
      framing_err <= fe_n;
    end
  end

  always_comb begin
    state_n = state;
    smp_n   = smp_cnt;
    bit_n   = bit_idx;
    shift_n = shift;
    data_n  = byte_data;
    bv_n    = 1'b0;
    fe_n    = 1'b0;

    // Divider is held at zero while idle so it restarts on the start edge.
    if (state == IDLE || state == WAIT_HIGH) begin
      div_n = '0;
    end else begin
      div_n = tick ? '0 : div_cnt + 1'b1;
    end

    case (state)
      IDLE: begin
        if (fall) begin
          state_n = START;
          smp_n   = '0;
        end
      end
      START: begin
        if (tick) begin
          if (smp_cnt == SMP_MID) begin
            smp_n   = '0;
            bit_n   = '0;
            // A line already back high at mid-start was only a glitch.
            state_n = line ? IDLE : DATA;
          end else begin
            smp_n = smp_cnt + 1'b1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (smp_cnt == SMP_LAST) begin
            smp_n   = '0;
            shift_n = {line, shift[DATA_W-1:1]};
            if (bit_idx == 3'd7) begin
              state_n = STOP;
            end else begin
              bit_n = bit_idx + 1'b1;
            end
          end else begin
            smp_n = smp_cnt + 1'b1;
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (smp_cnt == SMP_LAST) begin
            smp_n = '0;
            if (line) begin
              state_n = IDLE;
              bv_n    = 1'b1;
              data_n  = shift;
            end else begin
              state_n = WAIT_HIGH;
              fe_n    = 1'b1;
            end
          end else begin
            smp_n = smp_cnt + 1'b1;
          end
        end
      end
      WAIT_HIGH: begin
        if (line) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: rtl/robot_uart_stream_rx.sv
// robot_uart_stream_rx
// Receives the robot base's serial return stream, parses sensor-stream frames
// (0x13, N, N payload bytes, checksum) and latches the bump/wheel-drop byte.
//   clk, rst_n   : system clock, asynchronous active-low reset
//   uart_in      : serial line from the robot (asynchronous, idles high)
//   byte_data    : last received byte;  byte_valid : strobe for it
//   framing_err  : strobe, stop bit sampled low
//   frame_ok     : strobe, frame checksum passed
//   frame_err    : strobe, frame aborted or checksum failed
//   sensor_bits  : payload byte following ID 7, bits [4:0], latched on frame_ok
//   in_frame     : parser is between header and checksum
module robot_uart_stream_rx
  import robot_uart_pkg::*;
#(
  parameter int CLK_FREQ    = 50_000_000,
  parameter int BAUD        = 115_200,
  parameter int OVERSAMPLE  = 16,
  parameter int MAX_LEN     = 16,
  parameter int TIMEOUT_CYC = 50_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              uart_in,
  output logic [DATA_W-1:0] byte_data,
  output logic              byte_valid,
  output logic              framing_err,
  output logic              frame_ok,
  output logic              frame_err,
  output logic [4:0]        sensor_bits,
  output logic              in_frame
);

  localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TO_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  parse_state_t      p_state, p_n;
  logic [DATA_W-1:0] sum, sum_n;
  logic [DATA_W-1:0] len, len_n;
  logic [DATA_W-1:0] idx, idx_n;
  logic [DATA_W-1:0] csum;
  logic              ok_n, err_n;
  logic [4:0]        sens_n;
  logic [TO_W-1:0]   to_cnt;
  logic              timeout;
  logic              hit;
  logic [4:0]        hit_bits;
  logic [DATA_W-1:0] pay_buf [MAX_LEN];

  uart_rx_core #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD       (BAUD),
    .OVERSAMPLE (OVERSAMPLE)
  ) u_core (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_async    (uart_in),
    .byte_data   (byte_data),
    .byte_valid  (byte_valid),
    .framing_err (framing_err)
  );

  assign in_frame = (p_state != WAIT_HDR);
  assign timeout  = in_frame && (to_cnt == TO_LAST);
  assign csum     = sum + byte_data;

  // First even-index ID 7 that has a data byte after it inside the payload.
  always_comb begin
    hit      = 1'b0;
    hit_bits = sensor_bits;
    for (int i = 0; i < MAX_LEN - 1; i += 2) begin
      if (!hit && (DATA_W'(i + 1) < len) && (pay_buf[i] == SENSOR_ID)) begin
        hit      = 1'b1;
        hit_bits = pay_buf[i+1][4:0];
      end
    end
  end

  always_comb begin
    p_n    = p_state;
    sum_n  = sum;
    len_n  = len;
    idx_n  = idx;
    ok_n   = 1'b0;
    err_n  = 1'b0;
    sens_n = sensor_bits;

    // Aborts win over byte handling, so a framing error during GET_CSUM
    // produces a single frame_err rather than a checksum verdict.
    if (in_frame && (framing_err || timeout)) begin
      p_n   = WAIT_HDR;
      err_n = 1'b1;
    end else if (byte_valid) begin
      case (p_state)
        WAIT_HDR: begin
          if (byte_data == HDR_BYTE) begin
            sum_n = HDR_BYTE;
            p_n   = GET_LEN;
          end
        end
        GET_LEN: begin
          if (byte_data == '0 || byte_data > DATA_W'(MAX_LEN)) begin
            err_n = 1'b1;
            p_n   = WAIT_HDR;
          end else begin
            len_n = byte_data;
            sum_n = csum;
            idx_n = '0;
            p_n   = GET_PAY;
          end
        end
        GET_PAY: begin
          sum_n = csum;
          idx_n = idx + 1'b1;
          if (idx + 1'b1 == len) p_n = GET_CSUM;
        end
        GET_CSUM: begin
          if (csum == '0) begin
            ok_n   = 1'b1;
            sens_n = hit_bits;
          end else begin
            err_n = 1'b1;
          end
          p_n = WAIT_HDR;
        end
        default: p_n = WAIT_HDR;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_state     <= WAIT_HDR;
      sum         <= '0;
      len         <= '0;
      idx         <= '0;
      frame_ok    <= 1'b0;
      frame_err   <= 1'b0;
      sensor_bits <= '0;
      to_cnt      <= '0;
    end else begin
      p_state     <= p_n;
      sum         <= sum_n;
      len         <= len_n;
      idx         <= idx_n;
      frame_ok    <= ok_n;
      frame_err   <= err_n;
      sensor_bits <= sens_n;
      // Inter-byte watchdog only runs inside a frame.
      if (p_n == WAIT_HDR || byte_valid) begin
        to_cnt <= '0;
      end else begin
        to_cnt <= to_cnt + 1'b1;
      end
    end
  end

  // Payload storage carries data only; its validity is governed by len.
  always_ff @(posedge clk) begin
    if (byte_valid && p_state == GET_PAY) begin
      pay_buf[idx[IDX_W-1:0]] <= byte_data;
    end
  end

endmodule

// File: tb/tb_robot_uart_stream_rx.sv
module tb_robot_uart_stream_rx;

  // Fast line rate keeps the run short: DIV = 4, 64 clocks per bit.
  localparam int CLK_FREQ    = 50_000_000;
  localparam int BAUD        = 781_250;
  localparam int OVERSAMPLE  = 16;
  localparam int MAX_LEN     = 16;
  localparam int TIMEOUT_CYC = 1500;
  localparam int BIT_CLK     = 64;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       uart_in = 1'b1;
  logic [7:0] byte_data;
  logic       byte_valid, framing_err, frame_ok, frame_err, in_frame;
  logic [4:0] sensor_bits;

  int n_vec  = 0;
  int n_miss = 0;
  int n_byte = 0, n_fe = 0, n_ok = 0, n_err = 0;
  int b0, fe0, ok0, err0;
  logic [7:0] rx_log [$];
  logic [39:0] vec;

  always #10 clk = ~clk;

  robot_uart_stream_rx #(
    .CLK_FREQ    (CLK_FREQ),
    .BAUD        (BAUD),
    .OVERSAMPLE  (OVERSAMPLE),
    .MAX_LEN     (MAX_LEN),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .uart_in     (uart_in),
    .byte_data   (byte_data),
    .byte_valid  (byte_valid),
    .framing_err (framing_err),
    .frame_ok    (frame_ok),
    .frame_err   (frame_err),
    .sensor_bits (sensor_bits),
    .in_frame    (in_frame)
  );

  // Strobe monitor: counts high cycles of each strobe and logs bytes.
  always @(negedge clk) begin
    if (byte_valid) begin
      rx_log.push_back(byte_data);
      n_byte++;
    end
    if (framing_err) n_fe++;
    if (frame_ok)    n_ok++;
    if (frame_err)   n_err++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    b0 = n_byte; fe0 = n_fe; ok0 = n_ok; err0 = n_err;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    uart_in = 1'b0;
    repeat (BIT_CLK) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_in = b[i];
      repeat (BIT_CLK) @(negedge clk);
    end
    uart_in = stop;
    repeat (BIT_CLK) @(negedge clk);
    uart_in = 1'b1;
  endtask

  // Sends the n low-order bytes of v, most significant first.
  task automatic send_seq(input logic [39:0] v, input int n);
    for (int k = 0; k < n; k++) send_byte(v[8*(n-1-k) +: 8], 1'b1);
  endtask

  initial begin
    // Reset state
    repeat (5) @(negedge clk);
    check("rst_outputs", 32'({byte_data, byte_valid, framing_err, frame_ok, frame_err}), 32'd0);
    check("rst_sensor", 32'(sensor_bits), 32'd0);
    check("rst_in_frame", 32'(in_frame), 32'd0);
    rst_n = 1'b1;
    repeat (BIT_CLK) @(negedge clk);

    // 1: good frame with sensor packet
    snap();
    vec = 40'h13_02_07_03_E1;
    send_seq(vec, 5);
    repeat (8) @(negedge clk);
    check("t1_byte_count", n_byte - b0, 5);
    for (int k = 0; k < 5; k++)
      check("t1_byte_value", 32'(rx_log[b0 + k]), 32'(vec[8*(4-k) +: 8]));
    check("t1_frame_ok", n_ok - ok0, 1);
    check("t1_frame_err", n_err - err0, 0);
    check("t1_sensor", 32'(sensor_bits), 32'h03);
    check("t1_in_frame", 32'(in_frame), 32'd0);
    check("t1_byte_data", 32'(byte_data), 32'hE1);

    // 2: bad checksum
    snap();
    send_seq(40'h13_02_07_03_E0, 5);
    repeat (8) @(negedge clk);
    check("t2_frame_ok", n_ok - ok0, 0);
    check("t2_frame_err", n_err - err0, 1);
    check("t2_sensor", 32'(sensor_bits), 32'h03);

    // 3: short low glitch, then ID 7 with no following byte
    snap();
    uart_in = 1'b0;
    repeat (12) @(negedge clk);
    uart_in = 1'b1;
    repeat (2 * BIT_CLK) @(negedge clk);
    check("t3_glitch_bytes", n_byte - b0, 0);
    check("t3_glitch_fe", n_fe - fe0, 0);
    send_seq(40'h13_01_07_E5, 4);
    repeat (8) @(negedge clk);
    check("t3_byte_count", n_byte - b0, 4);
    check("t3_frame_ok", n_ok - ok0, 1);
    check("t3_frame_err", n_err - err0, 0);
    check("t3_sensor", 32'(sensor_bits), 32'h03);

    // 4: framing error mid-frame, then recovery
    snap();
    send_seq(40'h13_02, 2);
    repeat (4) @(negedge clk);
    check("t4_in_frame_before", 32'(in_frame), 32'd1);
    send_byte(8'h55, 1'b0);
    repeat (BIT_CLK) @(negedge clk);
    check("t4_framing_err", n_fe - fe0, 1);
    check("t4_frame_err", n_err - err0, 1);
    check("t4_byte_count", n_byte - b0, 2);
    check("t4_in_frame_after", 32'(in_frame), 32'd0);
    snap();
    send_seq(40'h13_02_07_1F_C5, 5);
    repeat (8) @(negedge clk);
    check("t4_frame_ok", n_ok - ok0, 1);
    check("t4_sensor", 32'(sensor_bits), 32'h1F);

    // 5: oversize length, then inter-byte timeout
    snap();
    send_seq(40'h13_20, 2);
    repeat (8) @(negedge clk);
    check("t5_len_err", n_err - err0, 1);
    check("t5_len_in_frame", 32'(in_frame), 32'd0);
    snap();
    send_seq(40'h13_02_07_04, 4);
    repeat (1200) @(negedge clk);
    check("t5_pre_timeout_in_frame", 32'(in_frame), 32'd1);
    check("t5_pre_timeout_err", n_err - err0, 0);
    repeat (600) @(negedge clk);
    check("t5_timeout_err", n_err - err0, 1);
    check("t5_timeout_in_frame", 32'(in_frame), 32'd0);
    check("t5_timeout_ok", n_ok - ok0, 0);
    check("t5_sensor", 32'(sensor_bits), 32'h1F);

    // 6: reset during bit 4 of a byte inside a frame
    send_seq(40'h13, 1);
    repeat (4) @(negedge clk);
    check("t6_in_frame_before", 32'(in_frame), 32'd1);
    vec = 40'hA5;
    uart_in = 1'b0;
    repeat (BIT_CLK) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      uart_in = vec[i];
      repeat (BIT_CLK) @(negedge clk);
    end
    uart_in = vec[4];
    repeat (BIT_CLK / 2) @(negedge clk);
    rst_n = 1'b0;
    snap();
    repeat (3) @(negedge clk);
    check("t6_rst_outputs", 32'({byte_data, byte_valid, framing_err, frame_ok, frame_err}), 32'd0);
    check("t6_rst_sensor", 32'(sensor_bits), 32'd0);
    check("t6_rst_in_frame", 32'(in_frame), 32'd0);
    uart_in = 1'b1;
    repeat (10) @(negedge clk);
    rst_n = 1'b1;
    repeat (3 * BIT_CLK) @(negedge clk);
    check("t6_no_stray", (n_byte - b0) + (n_fe - fe0) + (n_ok - ok0) + (n_err - err0), 0);
    send_seq(40'h13_02_07_01_E3, 5);
    repeat (8) @(negedge clk);
    check("t6_frame_ok", n_ok - ok0, 1);
    check("t6_frame_err", n_err - err0, 0);
    check("t6_sensor", 32'(sensor_bits), 32'h01);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
